// File: rtl/pipeline_stall_ctrl.sv
// Purpose: IF/ID register plus control slice of ID/EX, applying freeze, bubble, flush and halt policy.
// Latency: IF->ID and ID->EX each one cycle; each hazard-stall cycle inserts one bubble into EX.
// Backpressure: Mem_stall freezes every register; stall holds IF/ID and drops PC_en; flush wins over stall.
module pipeline_stall_ctrl #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OP   = 5'b00000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             Mem_stall,
  input  logic             flush,
  input  logic [15:0]      instr_IF,
  input  logic [15:0]      PC_2_IF,
  input  logic             RegWrite_ID,
  input  logic [2:0]       Write_register_ID,
  output logic [15:0]      instr_ID,
  output logic [15:0]      PC_2_ID,
  output logic [4:0]       OpCode_ID,
  output logic             valid_ID,
  output logic             RegWrite_EX,
  output logic [2:0]       Write_register_EX,
  output logic [4:0]       OpCode_EX,
  output logic             valid_EX,
  output logic             PC_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  // Opcode carried by a bubble in the EX slice (the NOP opcode).
  localparam logic [4:0] BUBBLE_OP = 5'b00001;

  typedef enum logic {RUN, HALTED} state_t;

  // Control slice of the ID/EX register.
  typedef struct packed {
    logic       reg_write;
    logic [2:0] wr_reg;
    logic [4:0] opcode;
    logic       valid;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '{reg_write: 1'b0, wr_reg: 3'd0, opcode: BUBBLE_OP, valid: 1'b0};

  state_t   state;
  ex_ctrl_t ex_q;

  assign OpCode_ID         = instr_ID[15:11];
  assign RegWrite_EX       = ex_q.reg_write;
  assign Write_register_EX = ex_q.wr_reg;
  assign OpCode_EX         = ex_q.opcode;
  assign valid_EX          = ex_q.valid;
  assign halted            = (state == HALTED);

  // PC advances unless reset, halted, memory-frozen, or a hazard stall that no redirect overrides.
  assign PC_en = !rst && !halted && !Mem_stall && (flush || !stall);

  // Pipeline registers, halt FSM and stall counter, in priority rst > Mem_stall > halt > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      instr_ID     <= NOP_INSTR;
      PC_2_ID      <= 16'd0;
      valid_ID     <= 1'b0;
      ex_q         <= EX_BUBBLE;
      stall_cycles <= '0;
    end else if (Mem_stall) begin
      // Data memory busy: everything holds.
    end else if (state == HALTED) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
      ex_q     <= EX_BUBBLE;
    end else if (flush) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
      ex_q     <= EX_BUBBLE;
    end else if (stall) begin
      ex_q <= EX_BUBBLE;
      if (stall_cycles != {CNT_W{1'b1}}) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end else begin
      ex_q.reg_write <= RegWrite_ID && valid_ID;
      ex_q.wr_reg    <= Write_register_ID;
      ex_q.opcode    <= OpCode_ID;
      ex_q.valid     <= valid_ID;
      instr_ID       <= instr_IF;
      PC_2_ID        <= PC_2_IF;
      valid_ID       <= 1'b1;
      // A real halt instruction entering EX stops fetch from the next cycle on.
      if (valid_ID && (OpCode_ID == HALT_OP)) begin
        state <= HALTED;
      end
    end
  end

endmodule
